mem_stage: RTL and testbench

- Memory-access pipeline stage that sits directly downstream of the execute stage.
- Consumes the ALU result as the effective address, or as pass-through data for non-memory ops.
- Performs RV32I loads and stores over a valid/ready data-memory port, stalling execute while a request is outstanding.
- Delivers a one-cycle writeback pulse carrying the aligned, sign- or zero-extended load data or the ALU result.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/load_extract.sv | 27 ++
 rtl/mem_stage.sv | 212 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 codes, states,
// and the legality/alignment check for loads and stores.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Unsigned widths exist only for loads; unknown codes always fault.
    function automatic logic mem_fault(
        input logic [2:0] f3,
        input logic [1:0] off,
        input logic       is_store
    );
        logic f;
        f = 1'b1;
        case (f3)
            F3_B:    f = 1'b0;
            F3_BU:   f = is_store;
            F3_H:    f = off[0];
            F3_HU:   f = is_store | off[0];
            F3_W:    f = |off;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half lane of a load word and
// sign- or zero-extends it according to funct3.
module load_extract
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] sh;

    assign sh = rdata >> {addr, 3'b000};

    always_comb begin
        data = sh;
        case (funct3)
            F3_B:    data = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   data = {24'h0, sh[7:0]};
            F3_H:    data = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   data = {16'h0, sh[15:0]};
            default: data = sh;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: valid/ready data-memory port, one-cycle writeback pulse.
// Optional request timeout enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        mem_ready,
    output logic        dmem_valid,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_misaligned
);

    state_e      state_q, state_d;
    logic        dv_q, dv_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        wbv_q, wbv_d;
    logic        wbrw_q, wbrw_d;
    logic [4:0]  wbrd_q, wbrd_d;
    logic [31:0] wbdata_q, wbdata_d;
    logic        mis_q, mis_d;

    logic        accept;
    logic        is_mem;
    logic        fault;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;

    assign mem_ready = (state_q == ST_IDLE);
    assign accept    = ex_valid && mem_ready;
    assign is_mem    = ex_mem_read | ex_mem_write;
    assign fault     = mem_fault(ex_funct3, ex_alu_result[1:0], ex_mem_write);

    always_comb begin
        st_wdata = ex_rs2_data;
        st_wstrb = 4'b1111;
        case (ex_funct3)
            F3_B: begin
                st_wdata = {4{ex_rs2_data[7:0]}};
                st_wstrb = 4'b0001 << ex_alu_result[1:0];
            end
            F3_H: begin
                st_wdata = {2{ex_rs2_data[15:0]}};
                st_wstrb = 4'b0011 << ex_alu_result[1:0];
            end
            default: ;
        endcase
    end

    load_extract u_ext (
        .rdata  (dmem_rdata),
        .addr   (off_q),
        .funct3 (f3_q),
        .data   (ld_data)
    );

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic [31:0] tmo_unused;
    assign tmo_unused = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d  = state_q;
        dv_d     = dv_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        f3_d     = f3_q;
        off_d    = off_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        wbv_d    = 1'b0;
        wbrw_d   = wbrw_q;
        wbrd_d   = wbrd_q;
        wbdata_d = wbdata_q;
        mis_d    = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        if (accept) begin
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (!is_mem || fault) begin
                wbv_d    = 1'b1;
                wbrw_d   = ex_reg_write & ~is_mem;
                wbrd_d   = ex_rd;
                wbdata_d = ex_alu_result;
                mis_d    = is_mem;
            end else begin
                state_d = ST_BUSY;
                dv_d    = 1'b1;
                we_d    = ex_mem_write;
                addr_d  = {ex_alu_result[31:2], 2'b00};
                wdata_d = ex_mem_write ? st_wdata : 32'h0;
                wstrb_d = ex_mem_write ? st_wstrb : 4'h0;
                f3_d    = ex_funct3;
                off_d   = ex_alu_result[1:0];
                rd_d    = ex_rd;
                rw_d    = ex_reg_write & ex_mem_read;
            end
        end else if (state_q == ST_BUSY) begin
            if (dmem_ready) begin
                state_d  = ST_IDLE;
                dv_d     = 1'b0;
                wbv_d    = 1'b1;
                wbrw_d   = rw_q;
                wbrd_d   = rd_q;
                wbdata_d = we_q ? {addr_q[31:2], off_q} : ld_data;
            end
`ifdef MEM_STAGE_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d  = ST_IDLE;
                dv_d     = 1'b0;
                wbv_d    = 1'b1;
                wbrw_d   = 1'b0;
                wbrd_d   = rd_q;
                wbdata_d = {addr_q[31:2], off_q};
                mis_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dv_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            f3_q     <= '0;
            off_q    <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            wbv_q    <= 1'b0;
            wbrw_q   <= 1'b0;
            wbrd_q   <= '0;
            wbdata_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dv_q     <= dv_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            wbv_q    <= wbv_d;
            wbrw_q   <= wbrw_d;
            wbrd_q   <= wbrd_d;
            wbdata_q <= wbdata_d;
            mis_q    <= mis_d;
        end
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign dmem_valid     = dv_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_wstrb     = wstrb_q;
    assign wb_valid       = wbv_q;
    assign wb_reg_write   = wbrw_q;
    assign wb_rd          = wbrd_q;
    assign wb_data        = wbdata_q;
    assign mem_misaligned = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized check of mem_stage against an arithmetic model
// of RV32I load/store formatting, alignment and writeback timing.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        mem_ready;
    logic        dmem_valid;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_misaligned;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_alu_result  (ex_alu_result),
        .ex_rs2_data    (ex_rs2_data),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .mem_ready      (mem_ready),
        .dmem_valid     (dmem_valid),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .mem_misaligned (mem_misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit op_legal(input int kind, input logic [2:0] f3);
        if (kind == 2) return (f3 <= 3'd2);
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                               input logic [2:0] f3);
        int          sz;
        logic [31:0] mask;
        logic [31:0] v;
        sz   = op_size(f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = (w >> (8 * off)) & mask;
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // kind: 0 = ALU pass-through, 1 = load, 2 = store
    task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] rs2,
                         input logic [2:0] f3, input logic [4:0] rd, input logic rw,
                         input logic [31:0] rdata, input int delay);
        int          sz;
        int          off;
        bit          ok;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_load;
        sz  = op_size(f3);
        off = int'(a % 4);
        ok  = op_legal(kind, f3) && ((a % sz) == 0);
        chk("ready_before", 32'(mem_ready), 32'd1);
        ex_valid      = 1'b1;
        ex_alu_result = a;
        ex_rs2_data   = rs2;
        ex_mem_read   = (kind == 1);
        ex_mem_write  = (kind == 2);
        ex_funct3     = f3;
        ex_rd         = rd;
        ex_reg_write  = rw;
        step();
        ex_valid      = 1'b0;
        ex_alu_result = $urandom;
        ex_rs2_data   = $urandom;
        if (kind == 0 || !ok) begin
            chk("imm_wb_valid", 32'(wb_valid), 32'd1);
            chk("imm_wb_rd", 32'(wb_rd), 32'(rd));
            chk("imm_wb_rw", 32'(wb_reg_write), (kind == 0) ? 32'(rw) : 32'd0);
            chk("imm_misal", 32'(mem_misaligned), (kind == 0) ? 32'd0 : 32'd1);
            chk("imm_dvalid", 32'(dmem_valid), 32'd0);
            chk("imm_ready", 32'(mem_ready), 32'd1);
            if (kind == 0) chk("imm_wb_data", wb_data, a);
            return;
        end
        e_wdata = (kind == 1) ? 32'd0 :
                  (sz == 1) ? rs2[7:0] * 32'h0101_0101 :
                  (sz == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
        e_wstrb = (kind == 1) ? 4'd0 : 4'(((1 << sz) - 1) << off);
        e_load  = model_load(rdata, off, f3);
        chk("req_dvalid", 32'(dmem_valid), 32'd1);
        chk("req_ready_lo", 32'(mem_ready), 32'd0);
        chk("req_wb_quiet", 32'(wb_valid), 32'd0);
        for (int i = 0; i <= delay; i++) begin
            chk("req_hold_valid", 32'(dmem_valid), 32'd1);
            chk("req_we", 32'(dmem_we), (kind == 2) ? 32'd1 : 32'd0);
            chk("req_addr", dmem_addr, a - 32'(off));
            chk("req_wdata", dmem_wdata, e_wdata);
            chk("req_wstrb", 32'(dmem_wstrb), 32'(e_wstrb));
            if (i == delay) begin
                dmem_ready = 1'b1;
                dmem_rdata = rdata;
            end else begin
                dmem_ready = 1'b0;
                dmem_rdata = $urandom;
            end
            step();
            if (i < delay) chk("busy_no_wb", 32'(wb_valid), 32'd0);
        end
        dmem_ready = 1'b0;
        dmem_rdata = $urandom;
        chk("done_wb_valid", 32'(wb_valid), 32'd1);
        chk("done_dvalid", 32'(dmem_valid), 32'd0);
        chk("done_ready", 32'(mem_ready), 32'd1);
        chk("done_misal", 32'(mem_misaligned), 32'd0);
        chk("done_wb_rd", 32'(wb_rd), 32'(rd));
        chk("done_wb_rw", 32'(wb_reg_write), (kind == 1) ? 32'(rw) : 32'd0);
        if (kind == 1) chk("done_wb_data", wb_data, e_load);
    endtask

    initial begin
        rst           = 1'b1;
        ex_valid      = 1'b0;
        ex_alu_result = '0;
        ex_rs2_data   = '0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_funct3     = '0;
        ex_rd         = '0;
        ex_reg_write  = 1'b0;
        dmem_ready    = 1'b0;
        dmem_rdata    = '0;
        step();
        step();
        chk("rst_ready", 32'(mem_ready), 32'd1);
        chk("rst_dvalid", 32'(dmem_valid), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbrw", 32'(wb_reg_write), 32'd0);
        chk("rst_wbrd", 32'(wb_rd), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_misal", 32'(mem_misaligned), 32'd0);
        rst = 1'b0;
        step();

        do_op(0, 32'h0000_1234, 32'h0, 3'd0, 5'd5, 1'b1, 32'h0, 0);
        do_op(0, 32'hCAFE_0001, 32'h0, 3'd0, 5'd6, 1'b0, 32'h0, 0);
        do_op(2, 32'h0000_0103, 32'h0000_00AB, 3'd0, 5'd7, 1'b1, 32'h0, 3);
        do_op(1, 32'h0000_0102, 32'h0, 3'd0, 5'd8, 1'b1, 32'h0080_0000, 0);
        do_op(1, 32'h0000_0102, 32'h0, 3'd4, 5'd9, 1'b1, 32'h0080_0000, 0);
        do_op(1, 32'h0000_0201, 32'h0, 3'd2, 5'd10, 1'b1, 32'h0, 0);
        do_op(2, 32'h0000_0300, 32'h0, 3'd4, 5'd11, 1'b0, 32'h0, 0);
        step();
        chk("idle_wb_drop", 32'(wb_valid), 32'd0);
        chk("idle_misal_drop", 32'(mem_misaligned), 32'd0);

        ex_valid      = 1'b1;
        ex_alu_result = 32'h0000_0400;
        ex_mem_read   = 1'b1;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'd2;
        ex_rd         = 5'd12;
        ex_reg_write  = 1'b1;
        step();
        ex_valid = 1'b0;
        chk("rb_dvalid", 32'(dmem_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rb_dvalid_drop", 32'(dmem_valid), 32'd0);
        chk("rb_ready", 32'(mem_ready), 32'd1);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_ready = 1'b0;
        chk("rb_no_wb", 32'(wb_valid), 32'd0);
        chk("rb_still_idle", 32'(dmem_valid), 32'd0);
        step();
        chk("rb_no_wb2", 32'(wb_valid), 32'd0);

        for (int t = 0; t < 300; t++) begin
            logic [31:0] ra;
            ra = $urandom;
            do_op(int'($urandom_range(0, 2)), ra, $urandom, 3'($urandom_range(0, 7)),
                  5'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
